// File: rtl/busio_arbiter_if.sv
// Fetch port, memory load/store port and external bus shared by busio_arbiter and its surroundings.
// master = arbiter view, slave = pipeline plus external bus view.
interface busio_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  fetch_request;
    logic [ADDR_WIDTH-1:0] fetch_address;
    logic                  fetch_cancel;
    logic                  fetch_stall;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  fetch_ready;

    logic                  mem_request;
    logic                  mem_write;
    logic [STRB_WIDTH-1:0] mem_strobe;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_stall;
    logic [DATA_WIDTH-1:0] mem_read_data;
    logic                  mem_ready;

    logic                  bus_valid;
    logic                  bus_write;
    logic [STRB_WIDTH-1:0] bus_strobe;
    logic [ADDR_WIDTH-1:0] bus_address;
    logic [DATA_WIDTH-1:0] bus_write_data;
    logic [DATA_WIDTH-1:0] bus_read_data;
    logic                  bus_ready;

    modport master (
        input  fetch_request, fetch_address, fetch_cancel, fetch_stall,
        output fetch_data, fetch_ready,
        input  mem_request, mem_write, mem_strobe, mem_address, mem_write_data, mem_stall,
        output mem_read_data, mem_ready,
        output bus_valid, bus_write, bus_strobe, bus_address, bus_write_data,
        input  bus_read_data, bus_ready
    );

    modport slave (
        output fetch_request, fetch_address, fetch_cancel, fetch_stall,
        input  fetch_data, fetch_ready,
        output mem_request, mem_write, mem_strobe, mem_address, mem_write_data, mem_stall,
        input  mem_read_data, mem_ready,
        input  bus_valid, bus_write, bus_strobe, bus_address, bus_write_data,
        output bus_read_data, bus_ready
    );
endinterface

// File: rtl/busio_arbiter.sv
// Non-preemptive arbiter of fetch and memory-stage accesses onto one single-outstanding bus.
// Memory has priority; fetch is granted after MAX_MEM_STREAK memory grants while it waits.
module busio_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_MEM_STREAK = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    busio_arbiter_if.master bus_if
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int STREAK_W   = $clog2(MAX_MEM_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

    typedef enum logic [2:0] {IDLE, FETCH, MEM, FDONE, MDONE} state_e;

    state_e                state_q;
    logic [STREAK_W-1:0]   streak_q, streak_d;
    logic                  cancel_q;
    logic                  store_q;
    logic                  mem_wins;

    logic                  bus_valid_q;
    logic                  bus_write_q;
    logic [STRB_WIDTH-1:0] bus_strobe_q;
    logic [ADDR_WIDTH-1:0] bus_address_q;
    logic [DATA_WIDTH-1:0] bus_write_data_q;
    logic                  fetch_ready_q;
    logic [DATA_WIDTH-1:0] fetch_data_q;
    logic                  mem_ready_q;
    logic [DATA_WIDTH-1:0] mem_read_data_q;

    // Streak only advances while fetch is actually waiting behind memory.
    always_comb begin
        mem_wins = bus_if.mem_request &&
                   !(streak_q == STREAK_MAX && bus_if.fetch_request);
        streak_d = '0;
        if (mem_wins && bus_if.fetch_request)
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            streak_q         <= '0;
            cancel_q         <= 1'b0;
            store_q          <= 1'b0;
            bus_valid_q      <= 1'b0;
            bus_write_q      <= 1'b0;
            bus_strobe_q     <= '0;
            bus_address_q    <= '0;
            bus_write_data_q <= '0;
            fetch_ready_q    <= 1'b0;
            fetch_data_q     <= '0;
            mem_ready_q      <= 1'b0;
            mem_read_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    streak_q <= streak_d;
                    if (mem_wins) begin
                        state_q          <= MEM;
                        store_q          <= bus_if.mem_write;
                        bus_valid_q      <= 1'b1;
                        bus_write_q      <= bus_if.mem_write;
                        bus_strobe_q     <= bus_if.mem_write ? bus_if.mem_strobe : '1;
                        bus_address_q    <= bus_if.mem_address;
                        bus_write_data_q <= bus_if.mem_write ? bus_if.mem_write_data : '0;
                    end else if (bus_if.fetch_request) begin
                        // A cancel arriving with the new request refers to the old fetch.
                        state_q          <= FETCH;
                        cancel_q         <= 1'b0;
                        bus_valid_q      <= 1'b1;
                        bus_write_q      <= 1'b0;
                        bus_strobe_q     <= '1;
                        bus_address_q    <= bus_if.fetch_address;
                        bus_write_data_q <= '0;
                    end
                end
                FETCH: begin
                    if (bus_if.fetch_cancel) cancel_q <= 1'b1;
                    if (bus_if.bus_ready) begin
                        bus_valid_q      <= 1'b0;
                        bus_write_q      <= 1'b0;
                        bus_strobe_q     <= '0;
                        bus_address_q    <= '0;
                        bus_write_data_q <= '0;
                        cancel_q         <= 1'b0;
                        if (cancel_q || bus_if.fetch_cancel) begin
                            state_q <= IDLE;
                        end else begin
                            state_q       <= FDONE;
                            fetch_ready_q <= 1'b1;
                            fetch_data_q  <= bus_if.bus_read_data;
                        end
                    end
                end
                MEM: begin
                    if (bus_if.bus_ready) begin
                        state_q          <= MDONE;
                        bus_valid_q      <= 1'b0;
                        bus_write_q      <= 1'b0;
                        bus_strobe_q     <= '0;
                        bus_address_q    <= '0;
                        bus_write_data_q <= '0;
                        mem_ready_q      <= 1'b1;
                        mem_read_data_q  <= store_q ? '0 : bus_if.bus_read_data;
                    end
                end
                FDONE: begin
                    // Leaving a done state never grants; the consumed request is retired here.
                    if (bus_if.fetch_cancel || !bus_if.fetch_stall) begin
                        state_q       <= IDLE;
                        fetch_ready_q <= 1'b0;
                        fetch_data_q  <= '0;
                    end
                end
                MDONE: begin
                    if (!bus_if.mem_stall) begin
                        state_q         <= IDLE;
                        mem_ready_q     <= 1'b0;
                        mem_read_data_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.bus_valid      = bus_valid_q;
    assign bus_if.bus_write      = bus_write_q;
    assign bus_if.bus_strobe     = bus_strobe_q;
    assign bus_if.bus_address    = bus_address_q;
    assign bus_if.bus_write_data = bus_write_data_q;
    assign bus_if.fetch_ready    = fetch_ready_q;
    assign bus_if.fetch_data     = fetch_data_q;
    assign bus_if.mem_ready      = mem_ready_q;
    assign bus_if.mem_read_data  = mem_read_data_q;
endmodule

// File: tb/tb_busio_arbiter.sv
// Randomized and directed bench for busio_arbiter against a transaction-level reference model.
module tb_busio_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   dut_beats = 0;

    always #5 clk = ~clk;

    busio_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

    busio_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_MEM_STREAK(MAXS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus_if  (bif)
    );

    // Reference model: what the arbiter should be showing after each edge.
    logic          e_bv = 1'b0, e_bw = 1'b0, e_fr = 1'b0, e_mr = 1'b0;
    logic [SW-1:0] e_bs = '0;
    logic [AW-1:0] e_ba = '0;
    logic [DW-1:0] e_bwd = '0, e_fd = '0, e_md = '0;
    logic          fl_fetch = 1'b0, fl_cancel = 1'b0, fl_write = 1'b0;
    int            streak = 0;
    logic [AW-1:0] f_next = 32'h0000_1000;
    logic [AW-1:0] m_next = 32'h8000_0000;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        logic rn, fr, fc, fs, mr, mw, mst, br;
        logic [AW-1:0] fa, ma;
        logic [SW-1:0] ms;
        logic [DW-1:0] mwd, brd;
        rn = reset_n; fr = bif.fetch_request; fa = bif.fetch_address; fc = bif.fetch_cancel;
        fs = bif.fetch_stall; mr = bif.mem_request; mw = bif.mem_write; ms = bif.mem_strobe;
        ma = bif.mem_address; mwd = bif.mem_write_data; mst = bif.mem_stall;
        br = bif.bus_ready; brd = bif.bus_read_data;
        if (rn && bif.bus_valid === 1'b1 && br) dut_beats++;
        @(posedge clk);
        #1;
        if (!rn) begin
            e_bv = 0; e_bw = 0; e_bs = '0; e_ba = '0; e_bwd = '0;
            e_fr = 0; e_fd = '0; e_mr = 0; e_md = '0;
            streak = 0; fl_cancel = 0;
        end else if (e_bv) begin
            // One beat in flight: it finishes on bus_ready, a fetch cancelled meanwhile is dropped.
            if (fl_fetch && fc) fl_cancel = 1;
            if (br) begin
                e_bv = 0;
                if (fl_fetch) begin
                    if (!fl_cancel) begin e_fr = 1; e_fd = brd; end
                end else begin
                    e_mr = 1; e_md = fl_write ? '0 : brd;
                end
            end
        end else if (e_fr) begin
            if (fc || !fs) e_fr = 0;
        end else if (e_mr) begin
            if (!mst) e_mr = 0;
        end else begin
            if (mr && !(streak == MAXS && fr)) begin
                e_bv = 1; fl_fetch = 0; fl_write = mw;
                e_bw = mw; e_bs = mw ? ms : '1; e_ba = ma; e_bwd = mwd;
                streak = fr ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
            end else if (fr) begin
                e_bv = 1; fl_fetch = 1; fl_cancel = 0;
                e_bw = 0; e_bs = '1; e_ba = fa;
                streak = 0;
            end else begin
                streak = 0;
            end
        end
        check_eq("bus_valid", bif.bus_valid, e_bv);
        if (e_bv) begin
            check_eq("bus_write", bif.bus_write, e_bw);
            check_eq("bus_address", bif.bus_address, e_ba);
            check_eq("bus_strobe", bif.bus_strobe, e_bs);
            if (e_bw) check_eq("bus_write_data", bif.bus_write_data, e_bwd);
        end
        check_eq("fetch_ready", bif.fetch_ready, e_fr);
        if (e_fr) check_eq("fetch_data", bif.fetch_data, e_fd);
        check_eq("mem_ready", bif.mem_ready, e_mr);
        if (e_mr) check_eq("mem_read_data", bif.mem_read_data, e_md);
    endtask

    task automatic clear_inputs();
        bif.fetch_request = 0; bif.fetch_address = '0; bif.fetch_cancel = 0; bif.fetch_stall = 0;
        bif.mem_request = 0; bif.mem_write = 0; bif.mem_strobe = '0; bif.mem_address = '0;
        bif.mem_write_data = '0; bif.mem_stall = 0; bif.bus_ready = 0; bif.bus_read_data = '0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        clear_inputs();
        step();
        step();
        reset_n = 1;
    endtask

    task automatic new_fetch(input logic go);
        bif.fetch_request = go;
        if (go) begin bif.fetch_address = f_next; f_next = f_next + 4; end
    endtask

    task automatic new_mem(input logic go);
        bif.mem_request = go;
        if (go) begin
            bif.mem_write      = 1'($urandom_range(0, 1));
            bif.mem_strobe     = SW'($urandom);
            bif.mem_address    = m_next;
            bif.mem_write_data = $urandom;
            m_next = m_next + 4;
        end
    endtask

    task automatic drive_random();
        bif.fetch_cancel = 0;
        bif.fetch_stall  = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 19) == 0) begin
            bif.fetch_cancel = 1;
            new_fetch(1'($urandom_range(0, 1)));
        end else if (e_fr && !bif.fetch_stall) begin
            new_fetch($urandom_range(0, 3) != 0);
        end else if (!bif.fetch_request) begin
            new_fetch($urandom_range(0, 2) == 0);
        end
        bif.mem_stall = ($urandom_range(0, 2) == 0);
        if (e_mr && !bif.mem_stall) new_mem($urandom_range(0, 3) != 0);
        else if (!bif.mem_request) new_mem($urandom_range(0, 2) == 0);
        bif.bus_ready     = 1'($urandom_range(0, 1));
        bif.bus_read_data = $urandom;
    endtask

    initial begin
        int b0, cnt, mem_grants;
        logic got_fetch, first_is_mem, prev_bv, seen;

        clear_inputs();
        do_reset();
        check_eq("reset_bus_valid", bif.bus_valid, 0);
        check_eq("reset_fetch_ready", bif.fetch_ready, 0);
        check_eq("reset_mem_ready", bif.mem_ready, 0);
        check_eq("reset_mem_read_data", bif.mem_read_data, 0);

        // Load alone
        b0 = dut_beats;
        bif.mem_request = 1; bif.mem_write = 0; bif.mem_strobe = '1; bif.mem_address = 32'h100;
        bif.bus_ready = 1; bif.bus_read_data = 32'hDEADBEEF;
        step();
        check_eq("load_bus_valid", bif.bus_valid, 1);
        step();
        check_eq("load_mem_ready", bif.mem_ready, 1);
        check_eq("load_data", bif.mem_read_data, 32'hDEADBEEF);
        bif.mem_request = 0;
        step();
        step();
        check_eq("load_ready_drop", bif.mem_ready, 0);
        check_eq("load_beats", dut_beats - b0, 1);

        // Stall hold
        b0 = dut_beats; cnt = 0;
        bif.mem_request = 1; bif.mem_address = 32'h104; bif.mem_stall = 1;
        bif.bus_read_data = 32'h1234_5678;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            if (bif.mem_ready && bif.mem_read_data == 32'h1234_5678) cnt++;
            if (i == 4) begin bif.mem_stall = 0; bif.mem_request = 0; end
            step();
        end
        check_eq("stall_ready_cycles", cnt, 5);
        check_eq("stall_release", bif.mem_ready, 0);
        step();
        check_eq("stall_beats", dut_beats - b0, 1);

        // Contention then starvation cap
        do_reset();
        bif.bus_ready = 1; bif.bus_read_data = 32'h0BAD_F00D;
        bif.fetch_request = 1; bif.fetch_address = 32'h200;
        new_mem(1);
        mem_grants = 0; got_fetch = 0; first_is_mem = 0; prev_bv = 0;
        for (int i = 0; i < 60 && !got_fetch; i++) begin
            step();
            if (bif.bus_valid && !prev_bv) begin
                if (bif.bus_address == 32'h200) got_fetch = 1;
                else begin
                    if (mem_grants == 0) first_is_mem = 1;
                    mem_grants++;
                end
            end
            prev_bv = bif.bus_valid;
            if (e_mr) new_mem(1);
        end
        check_eq("contention_mem_first", first_is_mem, 1);
        check_eq("starve_fetch_granted", got_fetch, 1);
        check_eq("starve_mem_beats", mem_grants, MAXS);
        bif.mem_request = 0;
        for (int i = 0; i < 4; i++) begin
            if (e_fr) bif.fetch_request = 0;
            step();
        end

        // Cancel of an in-flight fetch
        do_reset();
        seen = 0;
        bif.fetch_request = 1; bif.fetch_address = 32'h40; bif.bus_ready = 0;
        step();
        check_eq("cancel_bus_addr", bif.bus_address, 32'h40);
        bif.fetch_cancel = 1; bif.fetch_request = 0;
        step();
        bif.fetch_cancel = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bif.bus_ready = 1;
            step();
            seen = seen | bif.fetch_ready;
        end
        step();
        seen = seen | bif.fetch_ready;
        check_eq("cancel_no_ready", seen, 0);
        bif.fetch_request = 1; bif.fetch_address = 32'h80; bif.bus_read_data = 32'hCAFE_0080;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bif.fetch_ready;
        end
        check_eq("refetch_ready", seen, 1);
        check_eq("refetch_data", bif.fetch_data, 32'hCAFE_0080);
        bif.fetch_request = 0;
        step();

        for (int i = 0; i < 3000; i++) begin
            drive_random();
            step();
        end

        // Reset while a beat is on the bus
        for (int i = 0; i < 50 && !e_bv; i++) begin
            drive_random();
            bif.bus_ready = 0;
            step();
        end
        check_eq("rst_mid_precond", bif.bus_valid, 1);
        reset_n = 0;
        clear_inputs();
        step();
        check_eq("rst_mid_bus_valid", bif.bus_valid, 0);
        check_eq("rst_mid_fetch_ready", bif.fetch_ready, 0);
        check_eq("rst_mid_mem_ready", bif.mem_ready, 0);
        reset_n = 1;

        for (int i = 0; i < 500; i++) begin
            drive_random();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
